// File: rtl/b02_line_scheduler.sv
// rtl/b02_line_scheduler.sv - round-robin arbiter serializing requester frames onto one recognizer line
// Each job: LEN frame bits LSB-first, two flush zeros, then a done cycle carrying the saturated U count.
module b02_line_scheduler #(
   parameter int NREQ = 4,
   parameter int LEN  = 8,
   parameter int CW   = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LEN-1:0]  frame,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic                 done,
   output logic [CW-1:0]        hits,
   output logic                 LINEA,
   input  logic                 U
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   idx;
   logic            found;
   logic [LEN-1:0]  sreg;
   logic [LEN-1:0]  pick_frame;
   logic [IW-1:0]   bidx;
   logic            dcnt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_inc;
   logic [PW-1:0]   ptr_next;

   // First requesting index at or above ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int j = 0; j < NREQ; j++) begin
         idx = PW'((int'(ptr) + j) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign pick_frame = frame[int'(pick)*LEN +: LEN];
   assign ptr_next   = (int'(pick) == NREQ - 1) ? '0 : pick + PW'(1);
   assign cnt_inc    = (U && cnt != {CW{1'b1}}) ? cnt + CW'(1) : cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hits  <= '0;
         LINEA <= 1'b0;
         sreg  <= '0;
         bidx  <= '0;
         dcnt  <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (found) begin
                  grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  busy  <= 1'b1;
                  LINEA <= pick_frame[0];
                  sreg  <= pick_frame >> 1;
                  ptr   <= ptr_next;
                  cnt   <= '0;
                  bidx  <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               cnt <= cnt_inc;
               if (int'(bidx) == LEN - 1) begin
                  LINEA <= 1'b0;
                  dcnt  <= 1'b0;
                  state <= DRAIN;
               end else begin
                  LINEA <= sreg[0];
                  sreg  <= sreg >> 1;
                  bidx  <= bidx + IW'(1);
               end
            end
            DRAIN: begin
               // The last flush edge still counts U, so hits takes the incremented value directly.
               if (dcnt) begin
                  hits  <= cnt_inc;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt  <= cnt_inc;
                  dcnt <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
